nibble_serializer: RTL

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

---
 rtl/nibble_serializer_pkg.sv | 14 +
 rtl/nibble_serializer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/nibble_serializer_pkg.sv
// Shared constants for the nibble serializer: nibble width, bit-counter width
// and the 2-bit FSM state encoding.
package nibble_serializer_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serializer.sv
// MSB-first nibble serializer with a 1-entry holding register, optional idle
// gap between frames, and a strobe/parity pulse once the far-end SIPO is full.
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NIBBLE_W-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic                sdo,
  output logic                word_strobe,
  output logic                parity_out,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NIBBLE_W - 1);
  localparam logic [3:0]       GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic [NIBBLE_W-1:0] shift_q, shift_d;
  logic [NIBBLE_W-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                ready_q, ready_d;
  logic                sdo_q, sdo_d;
  logic                strobe_q, strobe_d;
  logic                parity_q, parity_d;
  logic                nib_par_q, nib_par_d;
  logic                load_nibble;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      sdo_q       <= 1'b0;
      strobe_q    <= 1'b0;
      parity_q    <= 1'b0;
      nib_par_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      sdo_q       <= sdo_d;
      strobe_q    <= strobe_d;
      parity_q    <= parity_d;
      nib_par_q   <= nib_par_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    nib_par_d   = nib_par_q;
    sdo_d       = 1'b0;
    strobe_d    = 1'b0;
    parity_d    = 1'b0;
    load_nibble = 1'b0;

    unique case (state_q)
      ST_IDLE: load_nibble = hold_full_q;
      ST_SHIFT: begin
        if (cnt_q != LAST_BIT) begin
          sdo_d   = shift_q[NIBBLE_W-1];
          shift_d = {shift_q[NIBBLE_W-2:0], 1'b0};
          cnt_d   = cnt_q + 2'd1;
        end else begin
          // Bit 0 is on the wire this cycle; the far end captures it at this edge.
          strobe_d = 1'b1;
          parity_d = nib_par_q;
          if (GAP != 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            state_d     = ST_IDLE;
            load_nibble = hold_full_q;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d     = ST_IDLE;
          load_nibble = hold_full_q;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Moving the held nibble into the shifter puts its MSB on sdo immediately.
    if (load_nibble) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      sdo_d       = hold_q[NIBBLE_W-1];
      shift_d     = {hold_q[NIBBLE_W-2:0], 1'b0};
      nib_par_d   = ^hold_q;
      hold_full_d = 1'b0;
    end

    if (valid_in && ready_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    ready_d = !hold_full_d;
  end

  assign ready_out   = ready_q;
  assign sdo         = sdo_q;
  assign word_strobe = strobe_q;
  assign parity_out  = parity_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
